// File: rtl/exec_trace_fifo.sv
// Trace capture FIFO: snapshots pc/r0..r7 once per INSTR_FETCH_START entry as sequence-numbered records.
// Latency: record visible on rec_data one cycle after the capture cycle; no bypass from inputs.
// Backpressure: rec_valid/rec_ready drain; when full, captures are dropped and counted (never stalls). Optional: TRACE_DISPLAY_EN.
package constants_pkg;
  typedef enum logic [2:0] {
    CORE_IDLE         = 3'd0,
    INSTR_FETCH_START = 3'd1,
    INSTR_FETCH_WAIT  = 3'd2,
    INSTR_DECODE      = 3'd3,
    INSTR_EXECUTE     = 3'd4,
    INSTR_WRITEBACK   = 3'd5
  } ExecutionStage;
endpackage

module exec_trace_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  constants_pkg::ExecutionStage state,
  input  logic [7:0]                   pc,
  input  logic [7:0]                   r0,
  input  logic [7:0]                   r1,
  input  logic [7:0]                   r2,
  input  logic [7:0]                   r3,
  input  logic [7:0]                   r4,
  input  logic [7:0]                   r5,
  input  logic [7:0]                   r6,
  input  logic [7:0]                   r7,
  output logic                         rec_valid,
  input  logic                         rec_ready,
  output logic [87:0]                  rec_data,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [7:0]                   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [15:0] seq;
    logic [7:0]  pc;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [7:0]  r3;
    logic [7:0]  r4;
    logic [7:0]  r5;
    logic [7:0]  r6;
    logic [7:0]  r7;
  } rec_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   seq;
  logic          prev_fetch;

  logic fetch;
  logic capture;
  logic pop;
  logic push;
  logic drop;
  rec_t wr_rec;

  always_comb begin
    fetch   = (state == constants_pkg::INSTR_FETCH_START);
    capture = fetch && !prev_fetch;
    pop     = rec_valid && rec_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push    = capture && ((level != FULL_LVL) || pop);
    drop    = capture && (level == FULL_LVL) && !pop;
    wr_rec  = '{seq: seq, pc: pc, r0: r0, r1: r1, r2: r2, r3: r3,
                r4: r4, r5: r5, r6: r6, r7: r7};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      seq        <= '0;
      prev_fetch <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      prev_fetch <= fetch;
      if (capture) seq <= seq + 16'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= wr_rec;
  end

  assign rec_valid = (level != '0);
  assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

`ifdef TRACE_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!reset && push)
      $display("trace seq=%h pc=%h r0=%h r1=%h r2=%h r3=%h r4=%h r5=%h r6=%h r7=%h",
               seq, pc, r0, r1, r2, r3, r4, r5, r6, r7);
    if (!reset && drop)
      $display("trace DROP seq=%h", seq);
  end
`endif

endmodule

// File: tb/tb_exec_trace_fifo.sv
// Self-checking bench for exec_trace_fifo: vector table, directed corner sequences, random drain vs queue model.
module tb_exec_trace_fifo;
  import constants_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  ExecutionStage state;
  logic [7:0]    pc, r0, r1, r2, r3, r4, r5, r6, r7;
  logic          rec_ready;
  logic          rec_valid;
  logic [87:0]   rec_data;
  logic [4:0]    level;
  logic          overflow;
  logic [7:0]    drop_count;

  exec_trace_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .state(state), .pc(pc),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of records plus the capture/drop bookkeeping.
  logic [87:0] mq[$];
  int          m_seq   = 0;
  bit          m_prev  = 0;
  bit          m_ovf   = 0;
  int          m_drops = 0;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit fetch, cap, pop;
    fetch = (state == INSTR_FETCH_START);
    cap   = fetch && !m_prev;
    pop   = (mq.size() > 0) && rec_ready;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_seq = 0; m_prev = 0; m_ovf = 0; m_drops = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        if (mq.size() < DEPTH) mq.push_back({m_seq[15:0], pc, r0, r1, r2, r3, r4, r5, r6, r7});
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
        m_seq = (m_seq + 1) % 65536;
      end
      m_prev = fetch;
    end
    chk("model_level", level, mq.size());
    chk("model_valid", rec_valid, mq.size() != 0);
    chk("model_data", rec_data, (mq.size() != 0) ? mq[0] : 88'h0);
    chk("model_overflow", overflow, m_ovf);
    chk("model_drops", drop_count, m_drops);
  endtask

  task automatic fetch_once();
    state = INSTR_FETCH_START;
    cycle();
    state = INSTR_EXECUTE;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    state = INSTR_EXECUTE;
    rec_ready = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic rand_regs();
    pc = 8'($urandom); r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    r3 = 8'($urandom); r4 = 8'($urandom); r5 = 8'($urandom); r6 = 8'($urandom);
    r7 = 8'($urandom);
  endtask

  typedef struct {
    bit          rst;
    bit          fetch;
    bit          rdy;
    logic [7:0]  pcv;
    int          exp_level;
    logic [15:0] exp_seq;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          exp_next;
    bit          hold;
    logic [87:0] held;
    logic [87:0] first_rec;
    logic [15:0] last_seq;

    tbl[0] = '{1, 0, 0, 8'h00, 0, 16'h0000};
    tbl[1] = '{0, 1, 0, 8'h10, 1, 16'h0000};
    tbl[2] = '{0, 1, 0, 8'h10, 1, 16'h0000};
    tbl[3] = '{0, 1, 0, 8'h10, 1, 16'h0000};
    tbl[4] = '{0, 0, 0, 8'h10, 1, 16'h0000};
    tbl[5] = '{0, 1, 0, 8'h20, 2, 16'h0000};
    tbl[6] = '{0, 0, 1, 8'h20, 1, 16'h0001};
    tbl[7] = '{0, 0, 1, 8'h20, 0, 16'h0000};

    reset = 1'b1; state = INSTR_EXECUTE; rec_ready = 1'b0;
    pc = 8'h10; r0 = 8'h01; r1 = 8'h02; r2 = 8'h03; r3 = 8'h04;
    r4 = 8'h05; r5 = 8'h06; r6 = 8'h07; r7 = 8'h08;

    // Table: reset, 3-cycle fetch-start yields one record, second capture, drain.
    for (int i = 0; i < 8; i++) begin
      reset     = tbl[i].rst;
      state     = tbl[i].fetch ? INSTR_FETCH_START : INSTR_EXECUTE;
      rec_ready = tbl[i].rdy;
      pc        = tbl[i].pcv;
      cycle();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].exp_level);
      chk($sformatf("tbl%0d_seq", i), rec_data[87:72], tbl[i].exp_seq);
      if (i == 3) begin
        first_rec = {16'h0000, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        chk("first_record", rec_data, first_rec);
      end
    end
    rec_ready = 1'b0;

    // 20 captures into DEPTH=16 with no consumer.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_regs();
      fetch_once();
    end
    chk("fill_level", level, 16);
    chk("fill_overflow", overflow, 1'b1);
    chk("fill_drops", drop_count, 8'd4);
    rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_seq%0d", i), rec_data[87:72], 16'(i));
      cycle();
    end
    chk("drain_empty", rec_valid, 1'b0);
    rec_ready = 1'b0;

    // Full FIFO with capture and pop in the same cycle: no drop.
    for (int i = 0; i < 16; i++) begin
      rand_regs();
      fetch_once();
    end
    chk("full_level", level, 16);
    rand_regs();
    state = INSTR_FETCH_START;
    rec_ready = 1'b1;
    cycle();
    state = INSTR_EXECUTE;
    rec_ready = 1'b0;
    chk("pushpop_level", level, 16);
    chk("pushpop_drops", drop_count, 8'd4);
    rec_ready = 1'b1;
    last_seq = 16'h0;
    for (int i = 0; i < 16; i++) begin
      last_seq = rec_data[87:72];
      cycle();
    end
    chk("pushpop_last_seq", last_seq, 16'd36);
    rec_ready = 1'b0;

    // Random backpressure, capture every 4 cycles, 100 instructions.
    do_reset();
    exp_next = 0;
    hold = 0;
    held = '0;
    for (int k = 0; k < 420; k++) begin
      if (k < 400 && k % 4 == 0) begin
        rand_regs();
        state = INSTR_FETCH_START;
      end else begin
        state = INSTR_EXECUTE;
      end
      rec_ready = (k >= 400) ? 1'b1 : 1'($urandom_range(0, 1));
      if (hold) chk("rand_stable", rec_data, held);
      if (rec_valid && rec_ready) begin
        chk("rand_contig", rec_data[87:72], 16'(exp_next));
        exp_next++;
      end
      hold = rec_valid && !rec_ready;
      held = rec_data;
      cycle();
    end
    chk("rand_count", exp_next, 100);
    chk("rand_nodrop", drop_count, 8'd0);
    rec_ready = 1'b0;

    // Reset mid-operation with level=5 and overflow set.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      rand_regs();
      fetch_once();
    end
    rec_ready = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    rec_ready = 1'b0;
    chk("pre_reset_level", level, 5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("post_reset_level", level, 0);
    chk("post_reset_valid", rec_valid, 1'b0);
    chk("post_reset_overflow", overflow, 1'b0);
    rand_regs();
    fetch_once();
    chk("post_reset_seq", rec_data[87:72], 16'h0000);
    chk("post_reset_level1", level, 1);

    // 300 drops while full: drop_count saturates, seq keeps counting.
    do_reset();
    for (int i = 0; i < 316; i++) begin
      rand_regs();
      fetch_once();
    end
    chk("sat_drops", drop_count, 8'd255);
    chk("sat_overflow", overflow, 1'b1);
    chk("sat_level", level, 16);
    rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    rec_ready = 1'b0;
    rand_regs();
    fetch_once();
    chk("sat_next_seq", rec_data[87:72], 16'd316);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_trace_fifo.md
# exec_trace_fifo

Verification-side capture buffer that sits beside the execution logger on the processor's architectural state. It snapshots PC and r0..r7 once per instruction, on entry to `INSTR_FETCH_START`, and queues each snapshot as a sequence-numbered record in a circular FIFO. A scoreboard drains the records over a valid/ready handshake. Overflow is counted, never stalls the core, and never corrupts queued records.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `clk` input 1: sole clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `state` input `ExecutionStage`: core execution stage (from `constants_pkg`).
- `pc` input 8: program counter, sampled at capture.
- `r0`..`r7` input 8 each: register file contents, sampled at capture.
- `rec_valid` output 1: head record available.
- `rec_ready` input 1: consumer accepts the head record.
- `rec_data` output 88: head record, packed `{seq[15:0], pc, r0, r1, r2, r3, r4, r5, r6, r7}` (seq in bits 87:72, r7 in 7:0).
- `level` output `$clog2(DEPTH)+1`: entries currently held.
- `overflow` output 1: sticky; set by the first dropped capture.
- `drop_count` output 8: dropped captures, saturating at 255.

## Operation
- Capture event:
  - Asserted in a cycle where `state == INSTR_FETCH_START` and the registered previous-cycle flag `prev_fetch` is 0.
  - `prev_fetch` is updated every cycle with `(state == INSTR_FETCH_START)`.
  - A multi-cycle fetch-start therefore yields exactly one capture.
- Sequence counter:
  - 16-bit `seq`, starts at 0.
  - Every capture event stamps the current `seq` into the record, then `seq` increments, wrapping 0xFFFF -> 0x0000.
  - `seq` advances on dropped captures too, so the consumer can detect gaps.
- Storage:
  - Array of `DEPTH` x 88 bits.
  - Write pointer, read pointer, and `level` counter.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- Push: on a capture event when `level < DEPTH`, or when `level == DEPTH` and a pop occurs in the same cycle.
- Drop: on a capture event when full with no same-cycle pop.
  - `overflow` is set.
  - `drop_count` increments unless already 255.
  - Neither FIFO contents nor pointers change.
- Pop: when `rec_valid && rec_ready` at posedge; the read pointer advances.
- `level` update rule:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop or on neither.
- `rec_valid = (level != 0)`.
- `rec_data` is the entry at the read pointer.
  - It must be held stable while `rec_valid && !rec_ready`.
  - It must be 0 when empty.
- `rec_ready` while empty is ignored.
- No state machine beyond the FIFO; the control state is `prev_fetch`, the pointers, `level`, `seq`, `overflow` and `drop_count`.

## Timing
- Reset values (asserted at a posedge):
  - Pointers, `level`, `seq` and `drop_count` = 0.
  - `overflow` = 0.
  - `prev_fetch` = 0.
  - `rec_valid` = 0; `rec_data` = 0.
  - Array contents are don't-care.
- Reset overrides same-cycle capture and pop.
- Reset mid-operation discards all queued records.
- If `state == INSTR_FETCH_START` in the first cycle after reset deassertion, that cycle captures with `seq = 0`.
- Capture latency:
  - The record is sampled at the posedge ending the capture cycle.
  - `rec_valid` rises and `rec_data` shows the record from that posedge; visible one cycle after the capture cycle.
  - No combinational bypass from `pc`/`r*` to `rec_data`.
- Pop latency: head advances at the accepting posedge; back-to-back pops every cycle are supported.
- Simultaneous push and pop when empty cannot occur, because `rec_valid` = 0 blocks pop.
- Simultaneous push and pop at `level == DEPTH`: accepted, no drop.

## Configuration
- `TRACE_DISPLAY_EN` defined:
  - On each push, `$display` one line: `trace seq=<hex> pc=<hex> r0=<hex> ... r7=<hex>`.
  - On each drop, `$display`: `trace DROP seq=<hex>`.
  - Simulation-only, with no effect on outputs.
- Undefined: no `$display` statements compiled; the block is fully synthesizable.

## Test plan
- Reset, then hold `state = INSTR_FETCH_START` for 3 cycles with `pc=0x10`, `r0..r7 = 0x01..0x08` and `rec_ready=0`:
  - Exactly one record, `level=1`.
  - `rec_data = {16'h0000, 8'h10, 8'h01, ..., 8'h08}`.
- 20 non-consecutive fetch-starts with `rec_ready=0`, `DEPTH=16`:
  - `level=16`, `overflow=1`, `drop_count=4`.
  - Then drain with `rec_ready=1`: seqs 0..15 in order.
- `level=16` with a capture and a pop in the same cycle:
  - `level` stays 16, `drop_count` unchanged.
  - The last record carries the next seq.
- `rec_ready` toggled randomly while a capture occurs every 4 cycles over 100 instructions:
  - Consumer sees seq 0..99 contiguous with no drops.
  - `rec_data` is stable whenever `rec_valid && !rec_ready`.
- Assert `reset` for 1 cycle with `level=5`:
  - Next cycle `level=0`, `rec_valid=0`, `overflow=0`.
  - The next capture carries seq 0.
- 300 drops while full: `drop_count` saturates at 255 while `seq` keeps advancing.
